// File: rtl/urv_dmem_wb_bridge.sv
// Data-memory responder for the uRV execute stage: each load/store strobe becomes
// one pipelined Wishbone B4 master cycle, with completion, error and stall reporting.
module urv_dmem_wb_bridge #(
    parameter int unsigned g_timeout_cycles = 255,
    parameter bit          g_posted_stores  = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_load_i,
    input  logic        dm_store_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,
    output logic        dm_error_o,
    output logic        dm_busy_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i
);

    localparam int CNT_BITS = $clog2(64'(g_timeout_cycles) + 64'd1);
    localparam int CNT_W    = (CNT_BITS > 8) ? CNT_BITS : 8;
    localparam logic [CNT_W-1:0] TIMEOUT    = CNT_W'(g_timeout_cycles);
    localparam bit               TIMEOUT_EN = (g_timeout_cycles != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             start;
    logic             finish;
    logic             fail;
    logic             is_store_req;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;

    // A simultaneous load and store strobe is resolved as a load.
    assign is_store_req = dm_store_i & ~dm_load_i;
    assign count_inc    = count + CNT_W'(1);
    assign dm_busy_o    = (state != ST_IDLE) | dm_load_i | (dm_store_i & ~g_posted_stores);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        fail       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (dm_load_i | dm_store_i) begin
                    start      = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!wb_stall_i) begin
                    if (wb_err_i) begin
                        fail = 1'b1;
                    end else if (wb_ack_i) begin
                        finish = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wb_err_i) begin
                    fail = 1'b1;
                end else if (wb_ack_i) begin
                    finish = 1'b1;
                end else if (TIMEOUT_EN && (count_inc == TIMEOUT)) begin
                    fail = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (finish | fail) begin
            state_next = ST_IDLE;
        end
    end

    // Bus outputs come from the next state so cyc/stb are registered yet exact.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wb_cyc_o        <= 1'b0;
            wb_stb_o        <= 1'b0;
            wb_we_o         <= 1'b0;
            wb_adr_o        <= '0;
            wb_sel_o        <= '0;
            wb_dat_o        <= '0;
            count           <= '0;
            dm_data_l_o     <= '0;
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            dm_error_o      <= 1'b0;
        end else begin
            wb_cyc_o <= (state_next != ST_IDLE);
            wb_stb_o <= (state_next == ST_REQ);
            if (start) begin
                wb_adr_o <= dm_addr_i;
                wb_sel_o <= dm_data_select_i;
                wb_dat_o <= dm_data_s_i;
                wb_we_o  <= is_store_req;
            end
            if ((state == ST_REQ) && !wb_stall_i) begin
                count <= '0;
            end else if (state == ST_WAIT) begin
                count <= count_inc;
            end
            dm_load_done_o <= (finish | fail) & ~wb_we_o;
            if ((finish | fail) & ~wb_we_o) begin
                dm_data_l_o <= fail ? '0 : wb_dat_i;
            end
            // Posted stores report at launch only; a failed non-posted store still completes.
            dm_store_done_o <= g_posted_stores ? (start & is_store_req)
                                               : ((finish | fail) & wb_we_o);
            dm_error_o <= fail;
        end
    end

endmodule

// File: tb/tb_urv_dmem_wb_bridge.sv
// Directed bench for urv_dmem_wb_bridge: a non-posted instance (timeout 4) and a
// posted-store instance share one hand-driven Wishbone slave; responses go through a scoreboard.
module tb_urv_dmem_wb_bridge;

    typedef struct packed {
        logic        ld;
        logic        sd;
        logic        err;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [3:0]  sel;
    logic        load0, store0, load1, store1;
    logic [31:0] wb_dat;
    logic        ack, err_in, stall;

    logic [31:0] data_l0, data_l1, adr0, adr1, dato0, dato1;
    logic [3:0]  sel0, sel1;
    logic        ld_done0, st_done0, err0, busy0, cyc0, stb0, we0;
    logic        ld_done1, st_done1, err1, busy1, cyc1, stb1, we1;

    int checks   = 0;
    int failures = 0;

    resp_t sb0[$];
    resp_t sb1[$];
    resp_t act0, act1;

    urv_dmem_wb_bridge #(.g_timeout_cycles(4), .g_posted_stores(1'b0)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n),
        .dm_addr_i(addr), .dm_data_s_i(sdata), .dm_data_select_i(sel),
        .dm_load_i(load0), .dm_store_i(store0),
        .dm_data_l_o(data_l0), .dm_load_done_o(ld_done0), .dm_store_done_o(st_done0),
        .dm_error_o(err0), .dm_busy_o(busy0),
        .wb_cyc_o(cyc0), .wb_stb_o(stb0), .wb_we_o(we0),
        .wb_adr_o(adr0), .wb_sel_o(sel0), .wb_dat_o(dato0),
        .wb_dat_i(wb_dat), .wb_ack_i(ack), .wb_err_i(err_in), .wb_stall_i(stall)
    );

    urv_dmem_wb_bridge #(.g_timeout_cycles(255), .g_posted_stores(1'b1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n),
        .dm_addr_i(addr), .dm_data_s_i(sdata), .dm_data_select_i(sel),
        .dm_load_i(load1), .dm_store_i(store1),
        .dm_data_l_o(data_l1), .dm_load_done_o(ld_done1), .dm_store_done_o(st_done1),
        .dm_error_o(err1), .dm_busy_o(busy1),
        .wb_cyc_o(cyc1), .wb_stb_o(stb1), .wb_we_o(we1),
        .wb_adr_o(adr1), .wb_sel_o(sel1), .wb_dat_o(dato1),
        .wb_dat_i(wb_dat), .wb_ack_i(ack), .wb_err_i(err_in), .wb_stall_i(stall)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic checkResp(input string name, input resp_t act, input bit have, input resp_t exp);
        checks++;
        if (!have) begin
            failures++;
            $display("[TB] FAIL %s unexpected response got=%h want=none", name, act);
        end else if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit which, input bit ld, input bit st,
                                 input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        addr  = a;
        sdata = d;
        sel   = s;
        if (which) begin
            load1  = ld;
            store1 = st;
        end else begin
            load0  = ld;
            store0 = st;
        end
    endtask

    task automatic clearStrobes();
        load0  = 1'b0;
        store0 = 1'b0;
        load1  = 1'b0;
        store1 = 1'b0;
    endtask

    // Scoreboard monitors: pop one expected response per reported completion/error.
    always @(negedge clk) begin
        if (ld_done0 || st_done0 || err0) begin
            act0 = '{ld: ld_done0, sd: st_done0, err: err0, data: (ld_done0 ? data_l0 : 32'h0)};
            if (sb0.size() == 0) checkResp("resp0", act0, 1'b0, '0);
            else checkResp("resp0", act0, 1'b1, sb0.pop_front());
        end
    end

    always @(negedge clk) begin
        if (ld_done1 || st_done1 || err1) begin
            act1 = '{ld: ld_done1, sd: st_done1, err: err1, data: (ld_done1 ? data_l1 : 32'h0)};
            if (sb1.size() == 0) checkResp("resp1", act1, 1'b0, '0);
            else checkResp("resp1", act1, 1'b1, sb1.pop_front());
        end
    end

    initial begin
        rst_n  = 1'b0;
        clearStrobes();
        addr   = '0;
        sdata  = '0;
        sel    = '0;
        wb_dat = '0;
        ack    = 1'b0;
        err_in = 1'b0;
        stall  = 1'b0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_cyc_stb_we", {cyc0, stb0, we0, cyc1, stb1, we1}, 32'h0);
        checkOutput("rst_adr", adr0 | adr1, 32'h0);
        checkOutput("rst_sel_dat", {28'h0, sel0 | sel1} | dato0 | dato1, 32'h0);
        checkOutput("rst_data_l", data_l0 | data_l1, 32'h0);
        checkOutput("rst_pulses", {ld_done0, st_done0, err0, busy0, ld_done1, st_done1, err1, busy1}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single load, zero-wait slave
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_1004, 32'h0, 4'b1111);
        sb0.push_back('{ld: 1'b1, sd: 1'b0, err: 1'b0, data: 32'hDEAD_BEEF});
        #1;
        checkOutput("ld_c0_busy", busy0, 32'h1);
        checkOutput("ld_c0_cyc", cyc0, 32'h0);
        tick();
        clearStrobes();
        checkOutput("ld_c1_cyc_stb", {cyc0, stb0, we0}, 32'h6);
        checkOutput("ld_c1_adr", adr0, 32'h0000_1004);
        checkOutput("ld_c1_sel", sel0, 32'hF);
        tick();
        checkOutput("ld_c2_cyc_stb", {cyc0, stb0}, 32'h2);
        ack    = 1'b1;
        wb_dat = 32'hDEAD_BEEF;
        tick();
        ack    = 1'b0;
        wb_dat = 32'h0;
        checkOutput("ld_c3_cyc", cyc0, 32'h0);
        checkOutput("ld_c3_done", ld_done0, 32'h1);
        checkOutput("ld_c3_data", data_l0, 32'hDEAD_BEEF);
        checkOutput("ld_c3_busy", busy0, 32'h0);
        tick();
        checkOutput("ld_c4_done", ld_done0, 32'h0);
        checkOutput("ld_c4_hold", data_l0, 32'hDEAD_BEEF);

        // Stalled non-posted byte store, with an ignored load strobe while in REQ
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_2003, 32'hAAAA_AAAA, 4'b1000);
        stall = 1'b1;
        sb0.push_back('{ld: 1'b0, sd: 1'b1, err: 1'b0, data: 32'h0});
        #1;
        checkOutput("st_c0_busy", busy0, 32'h1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            clearStrobes();
            checkOutput("st_stb", {cyc0, stb0, we0}, 32'h7);
            checkOutput("st_adr", adr0, 32'h0000_2003);
            checkOutput("st_sel", sel0, 32'h8);
            checkOutput("st_dat", dato0, 32'hAAAA_AAAA);
            checkOutput("st_busy", busy0, 32'h1);
            if (c == 2) begin
                load0 = 1'b1;
                $display("[TB] note: protocol violation issued on purpose, load strobe during REQ");
            end
            if (c == 4) stall = 1'b0;
        end
        tick();
        checkOutput("st_c5_stb", {cyc0, stb0}, 32'h2);
        checkOutput("st_c5_busy", busy0, 32'h1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput("st_c6_done", st_done0, 32'h1);
        checkOutput("st_c6_cyc", cyc0, 32'h0);
        checkOutput("st_c6_busy", busy0, 32'h0);
        tick();
        checkOutput("st_c7_nolaunch", {cyc0, stb0, st_done0}, 32'h0);
        checkOutput("st_c7_datahold", data_l0, 32'hDEAD_BEEF);

        // Posted store followed by a load as soon as busy drops
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_3000, 32'h1234_5678, 4'b1111);
        sb1.push_back('{ld: 1'b0, sd: 1'b1, err: 1'b0, data: 32'h0});
        #1;
        checkOutput("ps_c0_busy", busy1, 32'h0);
        tick();
        clearStrobes();
        checkOutput("ps_c1_done", st_done1, 32'h1);
        checkOutput("ps_c1_stb", {cyc1, stb1, we1}, 32'h7);
        checkOutput("ps_c1_busy", busy1, 32'h1);
        tick();
        checkOutput("ps_c2_busy", busy1, 32'h1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput("ps_c3_busy", busy1, 32'h0);
        checkOutput("ps_c3_cyc", cyc1, 32'h0);
        checkOutput("ps_c3_nodone", st_done1, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_3004, 32'h0, 4'b1111);
        sb1.push_back('{ld: 1'b1, sd: 1'b0, err: 1'b0, data: 32'h0BAD_F00D});
        #1;
        checkOutput("ps_c3_stb", stb1, 32'h0);
        tick();
        clearStrobes();
        checkOutput("ps_c4_stb", {cyc1, stb1, we1}, 32'h6);
        checkOutput("ps_c4_adr", adr1, 32'h0000_3004);
        tick();
        ack    = 1'b1;
        wb_dat = 32'h0BAD_F00D;
        tick();
        ack    = 1'b0;
        wb_dat = 32'h0;
        checkOutput("ps_c6_ld", {ld_done1, st_done1}, 32'h2);
        checkOutput("ps_c6_data", data_l1, 32'h0BAD_F00D);

        // Bus error on a load
        tick();
        checkOutput("be_datahold", data_l0, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'b1111);
        sb0.push_back('{ld: 1'b1, sd: 1'b0, err: 1'b1, data: 32'h0});
        tick();
        clearStrobes();
        tick();
        err_in = 1'b1;
        wb_dat = 32'hFFFF_FFFF;
        tick();
        err_in = 1'b0;
        wb_dat = 32'h0;
        checkOutput("be_c3_pulses", {ld_done0, st_done0, err0}, 32'h5);
        checkOutput("be_c3_data", data_l0, 32'h0);
        checkOutput("be_c3_cyc", cyc0, 32'h0);

        // Timeout with a silent slave
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'b1111);
        sb0.push_back('{ld: 1'b1, sd: 1'b0, err: 1'b1, data: 32'h0});
        tick();
        clearStrobes();
        checkOutput("to_c1_stb", stb0, 32'h1);
        for (int c = 2; c <= 5; c++) begin
            tick();
            checkOutput("to_wait_cyc_err", {cyc0, err0}, 32'h2);
        end
        tick();
        checkOutput("to_c6_cyc", cyc0, 32'h0);
        checkOutput("to_c6_err", {err0, ld_done0}, 32'h3);
        tick();
        checkOutput("to_c7_idle", {busy0, cyc0, err0}, 32'h0);

        // Reset during WAIT, then a normal load
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'b1111);
        tick();
        clearStrobes();
        tick();
        checkOutput("mr_c2_cyc", {cyc0, stb0}, 32'h2);
        rst_n = 1'b0;
        #1;
        checkOutput("mr_async_cyc", cyc0, 32'h0);
        checkOutput("mr_async_pulses", {ld_done0, st_done0, err0, busy0}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("mr_data_cleared", data_l0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_6010, 32'h0, 4'b1111);
        sb0.push_back('{ld: 1'b1, sd: 1'b0, err: 1'b0, data: 32'hCAFE_F00D});
        tick();
        clearStrobes();
        checkOutput("mr_c1_adr", adr0, 32'h0000_6010);
        tick();
        ack    = 1'b1;
        wb_dat = 32'hCAFE_F00D;
        tick();
        ack    = 1'b0;
        wb_dat = 32'h0;
        checkOutput("mr_c3_done", ld_done0, 32'h1);
        checkOutput("mr_c3_data", data_l0, 32'hCAFE_F00D);

        tick();
        tick();
        checkOutput("sb0_drained", sb0.size(), 32'h0);
        checkOutput("sb1_drained", sb1.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/urv_dmem_wb_bridge.md
# urv_dmem_wb_bridge

Data-memory responder for the uRV execute stage. It accepts the single-cycle load/store strobes, address, store data and byte select that the execute stage drives. It runs each access as one pipelined Wishbone B4 master cycle and returns load data, completion pulses and a stall request to the core. Bus errors and timeouts are reported to the exception logic.

## Interface
Parameters:
- g_timeout_cycles, 255: cycles after `wb_stb_o` acceptance with no ack/err before abort; 0 disables timeout.
- g_posted_stores, 0: 1 = store completion reported at launch, not at ack.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_n_i  in  1  reset; one clock; reset is asynchronous and active-low.
- dm_addr_i  in  32  access byte address.
- dm_data_s_i  in  32  store data, already lane-replicated.
- dm_data_select_i  in  4  byte lane enables.
- dm_load_i  in  1  load request strobe, one cycle.
- dm_store_i  in  1  store request strobe, one cycle.
- dm_data_l_o  out  32  raw 32-bit load word; the core extracts the byte/half.
- dm_load_done_o  out  1  one-cycle pulse, `dm_data_l_o` valid.
- dm_store_done_o  out  1  one-cycle pulse, store complete or posted.
- dm_error_o  out  1  one-cycle pulse on `wb_err_i` or timeout.
- dm_busy_o  out  1  stall request to the pipeline.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone control.
- wb_adr_o  out  32  byte address, as latched.
- wb_sel_o  out  4  byte select.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i, wb_err_i, wb_stall_i  in  1 each  Wishbone responses.

## Operation
- FSM states are IDLE, REQ, WAIT.
- **Acceptance.** A request is accepted in IDLE when `dm_load_i | dm_store_i` is high.
  - On acceptance, latch addr, data, sel and we (we = store). Go to REQ.
  - If both strobes are high, treat it as a load.
- **Requests outside IDLE.** A strobe in REQ or WAIT is a protocol violation. It is ignored, and the bench flags it.
- **REQ state.**
  - Outputs: `wb_cyc_o` = 1, `wb_stb_o` = 1.
  - When `wb_stall_i` = 0, the strobe is accepted. Go to WAIT, or complete immediately if ack/err is seen in the same cycle.
- **WAIT state.**
  - Outputs: `wb_cyc_o` = 1, `wb_stb_o` = 0.
  - On `wb_ack_i`: complete. On `wb_err_i`: fail. `wb_err_i` takes priority over `wb_ack_i`.
- **Complete.**
  - Next cycle: `wb_cyc_o` = 0 and the FSM returns to IDLE.
  - Load: `dm_data_l_o` <= `wb_dat_i` and `dm_load_done_o` pulses.
  - Store with g_posted_stores = 0: `dm_store_done_o` pulses.
- **Fail.**
  - As complete, except `dm_error_o` pulses.
  - Load: `dm_data_l_o` <= 0 and `dm_load_done_o` still pulses, so the core never hangs.
- **Timeout.**
  - An 8..32-bit counter is cleared on strobe acceptance and increments each cycle in WAIT.
  - When it equals g_timeout_cycles, treat it as fail.
  - REQ stalled indefinitely is not timed out; the slave owns `wb_stall_i`.
- **Posted stores (g_posted_stores = 1).**
  - `dm_store_done_o` pulses the cycle after acceptance.
  - A later error or timeout still pulses `dm_error_o`; there is no second done pulse.
- **Busy.** `dm_busy_o` = (state != IDLE) | `dm_load_i` | (`dm_store_i` & !g_posted_stores), combinational.
  - A posted store leaves `dm_busy_o` low in the accept cycle, but it is high afterwards until IDLE.
  - This keeps ordering: the next access waits for the previous one.
- **Ignored inputs.** `wb_ack_i`/`wb_err_i` seen in IDLE are ignored.

## Timing
- **Reset values.** All outputs are 0: cyc, stb, we, adr, sel, dat, dm_data_l_o, and all pulses. The FSM is in IDLE and the counter is 0.
- **Reset mid-operation.** Asserting reset mid-transaction drops `wb_cyc_o` asynchronously, with no done or error pulse.
- **Registered outputs.** All Wishbone outputs are registered. `wb_cyc_o`/`wb_stb_o` rise one cycle after the request strobe.
- **Load latency.**
  - With a zero-wait slave (ack the cycle after stb): request at cycle 0, stb at cycle 1, ack at cycle 2, then `dm_load_done_o` + data at cycle 3, and `dm_busy_o` low at cycle 3.
  - Each `wb_stall_i` cycle and each ack wait cycle adds 1.
- **Back-to-back requests.** Minimum spacing is 3 cycles (IDLE re-entered at cycle 3, next strobe accepted there).
- **Hold behaviour.** `wb_adr_o`/`wb_sel_o`/`wb_dat_o`/`wb_we_o` hold from REQ entry until the return to IDLE.
- **Data hold.** `dm_data_l_o` holds until the next load completes.

## Test plan
- **Single load.** Load at 0x0000_1004, sel 1111, slave acks after 1 cycle with 0xDEADBEEF.
  - Required: `dm_data_l_o` = 0xDEADBEEF with a `dm_load_done_o` pulse at cycle 3.
  - Required: `wb_cyc_o` high for exactly cycles 1–2.
- **Stalled store, non-posted.** Byte store 0x000000AA replicated, addr 0x2003, sel 1000; `wb_stall_i` high for 3 cycles.
  - Required: stb held 4 cycles with stable adr/sel/dat.
  - Required: `dm_store_done_o` one cycle after ack, and `dm_busy_o` high throughout.
- **Posted store then load.** Store, then a load issued as soon as `dm_busy_o` drops.
  - Required: `dm_store_done_o` at cycle 1.
  - Required: the load's stb does not start before the store's `wb_cyc_o` drops.
- **Bus error.** Load answered with `wb_err_i`.
  - Required: `dm_error_o` and `dm_load_done_o` pulse together, and `dm_data_l_o` = 0.
- **Timeout.** g_timeout_cycles = 4, slave never acks.
  - Required: cyc drops and `dm_error_o` pulses 4 cycles after strobe acceptance, then the FSM is back in IDLE.
- **Mid-transaction reset.** Assert `rst_n_i` low in WAIT.
  - Required: `wb_cyc_o` drops immediately with no pulses, and the next load after release completes normally.
